trb_in_dispatch: RTL and testbench

- Input-side scheduler for the turbo decoder array; the counterpart of the output mux/arbiter.
- Accepts one Avalon-ST byte stream of fixed-length turbo frames and steers each whole frame to one of NUM_TURBO decoder cores.
- Selection is round-robin among cores that have a free frame credit; a core returns a credit with a done pulse.
- Sits between the NLB AFU input stream and the per-core decoder input ports.

---
 rtl/trb_pkg.sv | 15 +
 rtl/trb_rr_pick.sv | 30 +++
 rtl/trb_in_dispatch.sv | 208 ++++++++++++++++++++
 tb/tb_trb_in_dispatch.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trb_pkg.sv
// Shared constants and state encoding for the turbo input dispatcher.
package trb_pkg;

    localparam int TRB_LEN  = 32'd1024;
    localparam int ST_LEN   = TRB_LEN / 32'd8;
    localparam int DW_DEF   = 32'd8;
    localparam int BEAT_W   = 32'd11;
    localparam int CREDIT_W = 32'd4;

    typedef enum logic {
        ST_SEL  = 1'b0,
        ST_PASS = 1'b1
    } trb_state_t;

endpackage

// File: rtl/trb_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module trb_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          found,
    output logic [IW-1:0] grant
);

    int idx_s;

    // Scan last_grant+1 .. last_grant+N modulo N and keep the first hit
    always_comb begin
        found = 1'b0;
        grant = last_grant;
        idx_s = 0;
        for (int i = 1; i <= N; i++) begin
            idx_s = (int'(last_grant) + i) % N;
            if (!found && req[IW'(idx_s)]) begin
                found = 1'b1;
                grant = IW'(idx_s);
            end else begin
                grant = grant;
            end
        end
    end

endmodule

// File: rtl/trb_in_dispatch.sv
// Steers whole fixed-length frames to NUM_TURBO decoder cores by credit-gated round robin.
// Optional per-core completed-frame counters: define TRB_DISPATCH_STATS_EN.
module trb_in_dispatch
    import trb_pkg::*;
#(
    parameter int NUM_TURBO = 2,
    parameter int DW        = DW_DEF,
    parameter int FRAME_LEN = ST_LEN,
    parameter int MAX_OUT   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DW-1:0]           st_data_in,
    input  logic                    st_valid_in,
    input  logic                    st_sop_in,
    input  logic                    st_eop_in,
    output logic                    st_ready_out,
    output logic [DW*NUM_TURBO-1:0] dec_data_out,
    output logic [NUM_TURBO-1:0]    dec_valid_out,
    output logic [NUM_TURBO-1:0]    dec_sop_out,
    output logic [NUM_TURBO-1:0]    dec_eop_out,
    input  logic [NUM_TURBO-1:0]    dec_ready_in,
    input  logic [NUM_TURBO-1:0]    dec_done_in,
    output logic [NUM_TURBO-1:0]    dec_busy_out,
    output logic                    err_len,
    output logic                    err_sop,
    output logic [NUM_TURBO-1:0]    err_credit
`ifdef TRB_DISPATCH_STATS_EN
    ,
    output logic [16*NUM_TURBO-1:0] frame_cnt_out
`endif
);

    localparam int                 IW       = (NUM_TURBO > 1) ? $clog2(NUM_TURBO) : 1;
    localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(MAX_OUT);
    localparam logic [BEAT_W-1:0]   BEAT_SAT = {BEAT_W{1'b1}};
    localparam logic [BEAT_W:0]     LEN_EXP  = (BEAT_W+1)'(FRAME_LEN);

    trb_state_t            state_r;
    trb_state_t            state_nx_s;
    logic [IW-1:0]         sel_r;
    logic [IW-1:0]         last_r;
    logic [CREDIT_W-1:0]   credit_r [NUM_TURBO];
    logic [BEAT_W-1:0]     beat_cnt_r;
    logic [NUM_TURBO-1:0]  busy_r;
    logic [NUM_TURBO-1:0]  err_credit_r;
    logic                  err_len_r;
    logic                  err_sop_r;
    logic [NUM_TURBO-1:0]  req_s;
    logic [NUM_TURBO-1:0]  take_s;
    logic                  pick_found_s;
    logic [IW-1:0]         pick_idx_s;
    logic                  grant_s;
    logic                  acc_s;

    // Credit request vector and the core whose credit is consumed this cycle
    always_comb begin
        req_s  = {NUM_TURBO{1'b0}};
        take_s = {NUM_TURBO{1'b0}};
        for (int k = 0; k < NUM_TURBO; k++) begin
            req_s[k]  = (credit_r[k] != {CREDIT_W{1'b0}});
            take_s[k] = grant_s && (pick_idx_s == IW'(k));
        end
    end

    trb_rr_pick #(
        .N  (NUM_TURBO),
        .IW (IW)
    ) u_pick (
        .req        (req_s),
        .last_grant (last_r),
        .found      (pick_found_s),
        .grant      (pick_idx_s)
    );

    // Next state plus zero-latency forwarding of the stream to the selected core
    always_comb begin
        state_nx_s    = state_r;
        grant_s       = 1'b0;
        acc_s         = 1'b0;
        st_ready_out  = 1'b0;
        dec_data_out  = {(DW*NUM_TURBO){1'b0}};
        dec_valid_out = {NUM_TURBO{1'b0}};
        dec_sop_out   = {NUM_TURBO{1'b0}};
        dec_eop_out   = {NUM_TURBO{1'b0}};
        case (state_r)
            ST_SEL: begin
                grant_s = pick_found_s;
                if (pick_found_s) begin
                    state_nx_s = ST_PASS;
                end else begin
                    state_nx_s = ST_SEL;
                end
            end
            ST_PASS: begin
                st_ready_out = dec_ready_in[sel_r];
                acc_s        = st_valid_in & dec_ready_in[sel_r];
                for (int k = 0; k < NUM_TURBO; k++) begin
                    if (IW'(k) == sel_r) begin
                        dec_valid_out[k]         = st_valid_in;
                        dec_sop_out[k]           = st_sop_in;
                        dec_eop_out[k]           = st_eop_in;
                        dec_data_out[k*DW +: DW] = st_data_in;
                    end else begin
                        dec_valid_out[k]         = 1'b0;
                        dec_data_out[k*DW +: DW] = {DW{1'b0}};
                    end
                end
                if (acc_s && st_eop_in) begin
                    state_nx_s = ST_SEL;
                end else begin
                    state_nx_s = ST_PASS;
                end
            end
            default: state_nx_s = ST_SEL;
        endcase
    end

    // FSM, grant bookkeeping, beat counting and sticky framing errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_SEL;
            sel_r      <= {IW{1'b0}};
            last_r     <= IW'(NUM_TURBO - 1);
            beat_cnt_r <= {BEAT_W{1'b0}};
            err_len_r  <= 1'b0;
            err_sop_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (grant_s) begin
                sel_r      <= pick_idx_s;
                last_r     <= pick_idx_s;
                beat_cnt_r <= {BEAT_W{1'b0}};
            end else if (acc_s) begin
                if (beat_cnt_r != BEAT_SAT) begin
                    beat_cnt_r <= beat_cnt_r + BEAT_W'(1'b1);
                end
                if (st_eop_in && (((BEAT_W+1)'(beat_cnt_r) + (BEAT_W+1)'(1'b1)) != LEN_EXP)) begin
                    err_len_r <= 1'b1;
                end
                if ((beat_cnt_r == {BEAT_W{1'b0}}) && !st_sop_in) begin
                    err_sop_r <= 1'b1;
                end
                if ((beat_cnt_r != {BEAT_W{1'b0}}) && st_sop_in) begin
                    err_sop_r <= 1'b1;
                end
            end
        end
    end

    // Per-core credits; a grant and a done on the same core cancel out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TURBO; k++) begin
                credit_r[k] <= CRED_MAX;
            end
            busy_r       <= {NUM_TURBO{1'b0}};
            err_credit_r <= {NUM_TURBO{1'b0}};
        end else begin
            for (int k = 0; k < NUM_TURBO; k++) begin
                if (take_s[k] && dec_done_in[k]) begin
                    credit_r[k] <= credit_r[k];
                end else if (take_s[k]) begin
                    credit_r[k] <= credit_r[k] - CREDIT_W'(1'b1);
                end else if (dec_done_in[k] && (credit_r[k] != CRED_MAX)) begin
                    credit_r[k] <= credit_r[k] + CREDIT_W'(1'b1);
                end
                if (dec_done_in[k] && (credit_r[k] == CRED_MAX)) begin
                    err_credit_r[k] <= 1'b1;
                end
                busy_r[k] <= (credit_r[k] != CRED_MAX);
            end
        end
    end

    assign dec_busy_out = busy_r;
    assign err_len      = err_len_r;
    assign err_sop      = err_sop_r;
    assign err_credit   = err_credit_r;

`ifdef TRB_DISPATCH_STATS_EN
    logic [15:0] frame_cnt_r [NUM_TURBO];

    // Completed-frame counters, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TURBO; k++) begin
                frame_cnt_r[k] <= 16'd0;
            end
        end else begin
            for (int k = 0; k < NUM_TURBO; k++) begin
                if (acc_s && st_eop_in && (IW'(k) == sel_r)) begin
                    frame_cnt_r[k] <= frame_cnt_r[k] + 16'd1;
                end
            end
        end
    end

    // Flatten the counters onto the output bus
    always_comb begin
        frame_cnt_out = {(16*NUM_TURBO){1'b0}};
        for (int k = 0; k < NUM_TURBO; k++) begin
            frame_cnt_out[k*16 +: 16] = frame_cnt_r[k];
        end
    end
`endif

endmodule

// File: tb/tb_trb_in_dispatch.sv
// Self-checking bench for trb_in_dispatch: randomized frames against a frame-level credit/round-robin model.
module tb_trb_in_dispatch;

    localparam int N    = 2;
    localparam int DW   = 8;
    localparam int FL   = 128;
    localparam int MAXO = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   st_data_in;
    logic            st_valid_in;
    logic            st_sop_in;
    logic            st_eop_in;
    logic            st_ready_out;
    logic [DW*N-1:0] dec_data_out;
    logic [N-1:0]    dec_valid_out;
    logic [N-1:0]    dec_sop_out;
    logic [N-1:0]    dec_eop_out;
    logic [N-1:0]    dec_ready_in;
    logic [N-1:0]    dec_done_in;
    logic [N-1:0]    dec_busy_out;
    logic            err_len;
    logic            err_sop;
    logic [N-1:0]    err_credit;
`ifdef TRB_DISPATCH_STATS_EN
    logic [16*N-1:0] frame_cnt_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: credits, round-robin pointer, currently granted core
    int       m_credit [N];
    int       m_last;
    int       m_cur;
    bit       m_err_len;
    bit       m_err_sop;
    logic [N-1:0] m_err_credit;

    always #5 clk = ~clk;

    trb_in_dispatch #(
        .NUM_TURBO (N),
        .DW        (DW),
        .FRAME_LEN (FL),
        .MAX_OUT   (MAXO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .st_data_in    (st_data_in),
        .st_valid_in   (st_valid_in),
        .st_sop_in     (st_sop_in),
        .st_eop_in     (st_eop_in),
        .st_ready_out  (st_ready_out),
        .dec_data_out  (dec_data_out),
        .dec_valid_out (dec_valid_out),
        .dec_sop_out   (dec_sop_out),
        .dec_eop_out   (dec_eop_out),
        .dec_ready_in  (dec_ready_in),
        .dec_done_in   (dec_done_in),
        .dec_busy_out  (dec_busy_out),
        .err_len       (err_len),
        .err_sop       (err_sop),
        .err_credit    (err_credit)
`ifdef TRB_DISPATCH_STATS_EN
        ,
        .frame_cnt_out (frame_cnt_out)
`endif
    );

    function automatic void m_try_grant();
        bit got;
        got = 1'b0;
        if (m_cur < 0) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_last + i) % N;
                if (!got && m_credit[k] > 0) begin
                    got = 1'b1;
                    m_cur = k;
                    m_last = k;
                    m_credit[k] = m_credit[k] - 1;
                end
            end
        end
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < N; k++) m_credit[k] = MAXO;
        m_last = N - 1;
        m_cur = -1;
        m_err_len = 1'b0;
        m_err_sop = 1'b0;
        m_err_credit = '0;
        m_try_grant();
    endfunction

    function automatic void m_done(input int k);
        if (m_credit[k] == MAXO) m_err_credit[k] = 1'b1;
        else m_credit[k] = m_credit[k] + 1;
        m_try_grant();
    endfunction

    function automatic logic [N-1:0] m_busy();
        logic [N-1:0] b;
        for (int k = 0; k < N; k++) b[k] = (m_credit[k] != MAXO);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        st_valid_in = 1'b0;
        st_sop_in = 1'b0;
        st_eop_in = 1'b0;
        dec_done_in = '0;
        dec_ready_in = '1;
        repeat (3) tick();
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic pulse_done(input int k);
        dec_done_in = '0;
        dec_done_in[k] = 1'b1;
        tick();
        dec_done_in = '0;
        m_done(k);
    endtask

    // Drives one frame beat by beat and records where and how the beats came out
    task automatic send_frame(input int len, input bit sop_first, input int sop_extra,
                              input int abort_at, input bit rnd, input logic [N-1:0] done_end,
                              output int core_seen, output int bad, output int n_acc,
                              output bit eop_seen, output bit tmo);
        core_seen = -1; bad = 0; n_acc = 0; eop_seen = 1'b0; tmo = 1'b0;
        for (int i = 0; i < len && !tmo; i++) begin
            logic [DW-1:0] d;
            bit s, e, accepted;
            int wait_c;
            d = DW'($urandom);
            s = (i == 0) ? sop_first : (i == sop_extra);
            e = (i == len - 1);
            accepted = 1'b0;
            wait_c = 0;
            while (!accepted && !tmo) begin
                st_valid_in = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                st_data_in = d;
                st_sop_in = s;
                st_eop_in = e;
                if (rnd) dec_ready_in = N'($urandom_range(0, 3));
                @(negedge clk);
                if (st_valid_in && st_ready_out) begin
                    int c, cnt;
                    c = -1; cnt = 0;
                    accepted = 1'b1;
                    for (int k = 0; k < N; k++) if (dec_valid_out[k]) begin c = k; cnt++; end
                    if (cnt != 1) bad++;
                    else begin
                        if (core_seen < 0) core_seen = c;
                        else if (c != core_seen) bad++;
                        if (dec_data_out[c*DW +: DW] !== d || dec_sop_out[c] !== s || dec_eop_out[c] !== e) bad++;
                        for (int k = 0; k < N; k++)
                            if (k != c && dec_data_out[k*DW +: DW] !== '0) bad++;
                        if (e) eop_seen = 1'b1;
                    end
                end
                @(posedge clk);
                #1;
                wait_c++;
                if (wait_c > 400) tmo = 1'b1;
            end
            if (accepted) begin
                n_acc++;
                if (abort_at > 0 && n_acc == abort_at) begin
                    rst_n = 1'b0;
                    return;
                end
            end
        end
        st_valid_in = 1'b0;
        st_sop_in = 1'b0;
        st_eop_in = 1'b0;
        dec_ready_in = '1;
        if (!tmo) begin
            if (len != FL) m_err_len = 1'b1;
            if (!sop_first || sop_extra > 0) m_err_sop = 1'b1;
            m_cur = -1;
            m_try_grant();
            dec_done_in = done_end;
            for (int k = 0; k < N; k++) if (done_end[k]) m_done(k);
        end
        tick();
        dec_done_in = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        st_valid_in = 1'b1;
        st_sop_in = 1'b1;
        st_eop_in = 1'b0;
        st_data_in = 8'hA5;
        dec_ready_in = '1;
        dec_done_in = '0;
        repeat (3) tick();
        @(negedge clk);
        n_tests++;
        if ({st_ready_out, dec_valid_out, dec_sop_out, dec_eop_out, dec_data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_stream: got ready=%b valid=%b data=%h expected all 0", st_ready_out, dec_valid_out, dec_data_out);
        end
        n_tests++;
        if ({dec_busy_out, err_len, err_sop, err_credit} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%b len=%b sop=%b credit=%b expected all 0", dec_busy_out, err_len, err_sop, err_credit);
        end
        @(posedge clk);
        #1;
        st_valid_in = 1'b0;
        st_sop_in = 1'b0;
        rst_n = 1'b1;
        m_reset();
        repeat (3) tick();
        @(negedge clk);
        n_tests++;
        if (dec_busy_out !== m_busy()) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected %b", dec_busy_out, m_busy());
        end
        tick();
    endtask

    task automatic test_round_robin();
        int core, bad, nacc, exp_core, held_bad;
        bit eop, tmo;
        for (int f = 0; f < 4; f++) begin
            exp_core = m_cur;
            send_frame(FL, 1'b1, -1, -1, 1'b0, '0, core, bad, nacc, eop, tmo);
            n_tests++;
            if (core !== exp_core || exp_core !== (f % 2)) begin
                n_fail++;
                $display("FAIL rr_core frame %0d: got core %0d expected %0d", f, core, f % 2);
            end
            n_tests++;
            if (bad !== 0 || tmo || nacc !== FL || !eop) begin
                n_fail++;
                $display("FAIL rr_frame %0d: got bad=%0d tmo=%0b beats=%0d eop=%0b expected 0/0/%0d/1", f, bad, tmo, nacc, eop, FL);
            end
        end
        repeat (2) tick();
        @(negedge clk);
        n_tests++;
        if (dec_busy_out !== 2'b11 || m_busy() !== 2'b11) begin
            n_fail++;
            $display("FAIL rr_busy_full: got %b expected 11", dec_busy_out);
        end
        tick();
        held_bad = 0;
        st_valid_in = 1'b1;
        st_sop_in = 1'b1;
        st_data_in = 8'h3C;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (st_ready_out !== 1'b0 || dec_valid_out !== '0) held_bad++;
            tick();
        end
        n_tests++;
        if (held_bad !== 0) begin
            n_fail++;
            $display("FAIL rr_held: got %0d cycles not held expected 0", held_bad);
        end
    endtask

    task automatic test_done_regrant();
        int core, bad, nacc, exp_core;
        bit eop, tmo;
        pulse_done(1);
        exp_core = m_cur;
        send_frame(FL, 1'b1, -1, -1, 1'b0, '0, core, bad, nacc, eop, tmo);
        n_tests++;
        if (core !== 1 || exp_core !== 1 || bad !== 0 || tmo) begin
            n_fail++;
            $display("FAIL done_regrant: got core %0d bad=%0d tmo=%0b expected core 1 clean", core, bad, tmo);
        end
        n_tests++;
        if ({err_len, err_sop, err_credit} !== '0) begin
            n_fail++;
            $display("FAIL clean_flags: got len=%b sop=%b credit=%b expected 0", err_len, err_sop, err_credit);
        end
    endtask

    task automatic test_len_err();
        int core, bad, nacc, exp_core;
        bit eop, tmo;
        pulse_done(0);
        exp_core = m_cur;
        send_frame(100, 1'b1, -1, -1, 1'b0, '0, core, bad, nacc, eop, tmo);
        n_tests++;
        if (core !== exp_core || bad !== 0 || nacc !== 100 || !eop || tmo) begin
            n_fail++;
            $display("FAIL len_short_frame: got core %0d bad=%0d beats=%0d eop=%0b expected core %0d 100 beats eop", core, bad, nacc, eop, exp_core);
        end
        n_tests++;
        if (err_len !== m_err_len || !m_err_len) begin
            n_fail++;
            $display("FAIL err_len: got %b expected 1", err_len);
        end
        pulse_done(1);
        exp_core = m_cur;
        send_frame(FL, 1'b1, -1, -1, 1'b0, '0, core, bad, nacc, eop, tmo);
        n_tests++;
        if (core !== exp_core || exp_core !== 1 || bad !== 0 || tmo || err_len !== 1'b1 || err_sop !== 1'b0) begin
            n_fail++;
            $display("FAIL len_next_frame: got core %0d bad=%0d len=%b sop=%b expected core 1 clean len=1 sop=0", core, bad, err_len, err_sop);
        end
    endtask

    task automatic test_sop_err();
        int core, bad, nacc;
        bit eop, tmo;
        do_reset();
        send_frame(FL, 1'b0, -1, -1, 1'b0, '0, core, bad, nacc, eop, tmo);
        n_tests++;
        if (err_sop !== m_err_sop || !m_err_sop || core !== 0 || bad !== 0 || tmo) begin
            n_fail++;
            $display("FAIL sop_missing: got err_sop=%b core %0d bad=%0d expected 1 core 0 clean", err_sop, core, bad);
        end
        do_reset();
        @(negedge clk);
        n_tests++;
        if (err_sop !== 1'b0) begin
            n_fail++;
            $display("FAIL sop_cleared: got %b expected 0", err_sop);
        end
        tick();
        send_frame(FL, 1'b1, 5, -1, 1'b0, '0, core, bad, nacc, eop, tmo);
        n_tests++;
        if (err_sop !== 1'b1 || nacc !== FL || bad !== 0 || tmo) begin
            n_fail++;
            $display("FAIL sop_midframe: got err_sop=%b beats=%0d bad=%0d expected 1 %0d 0", err_sop, nacc, bad, FL);
        end
        send_frame(FL, 1'b1, -1, -1, 1'b0, '0, core, bad, nacc, eop, tmo);
        n_tests++;
        if (err_sop !== 1'b1 || core !== 1 || err_len !== 1'b0) begin
            n_fail++;
            $display("FAIL sop_sticky: got err_sop=%b core %0d err_len=%b expected 1 1 0", err_sop, core, err_len);
        end
    endtask

    task automatic test_credit_err();
        int core, bad, nacc;
        bit eop, tmo;
        do_reset();
        send_frame(FL, 1'b1, -1, -1, 1'b0, '0, core, bad, nacc, eop, tmo);
        send_frame(FL, 1'b1, -1, -1, 1'b0, 2'b01, core, bad, nacc, eop, tmo);
        repeat (2) tick();
        @(negedge clk);
        n_tests++;
        if (core !== 1 || dec_busy_out !== m_busy() || m_busy() !== 2'b11 || err_credit !== 2'b00) begin
            n_fail++;
            $display("FAIL credit_same_cycle: got core %0d busy=%b err=%b expected core 1 busy=11 err=00", core, dec_busy_out, err_credit);
        end
        tick();
        pulse_done(0);
        repeat (2) tick();
        @(negedge clk);
        n_tests++;
        if (dec_busy_out !== m_busy() || err_credit !== m_err_credit) begin
            n_fail++;
            $display("FAIL credit_return: got busy=%b err=%b expected busy=%b err=%b", dec_busy_out, err_credit, m_busy(), m_err_credit);
        end
        tick();
        pulse_done(0);
        repeat (2) tick();
        @(negedge clk);
        n_tests++;
        if (err_credit !== m_err_credit || m_err_credit !== 2'b01 || dec_busy_out !== 2'b10) begin
            n_fail++;
            $display("FAIL credit_overflow: got err=%b busy=%b expected err=01 busy=10", err_credit, dec_busy_out);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int core, bad, nacc;
        bit eop, tmo;
        send_frame(FL, 1'b1, -1, 60, 1'b0, '0, core, bad, nacc, eop, tmo);
        tick();
        @(negedge clk);
        n_tests++;
        if (nacc !== 60 || {st_ready_out, dec_valid_out, dec_eop_out, dec_data_out, dec_busy_out, err_len, err_sop, err_credit} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got beats=%0d ready=%b valid=%b eop=%b busy=%b errs=%b%b%b expected 60 and all 0",
                     nacc, st_ready_out, dec_valid_out, dec_eop_out, dec_busy_out, err_len, err_sop, err_credit);
        end
        @(posedge clk);
        #1;
        st_valid_in = 1'b0;
        rst_n = 1'b1;
        m_reset();
        send_frame(FL, 1'b1, -1, -1, 1'b0, '0, core, bad, nacc, eop, tmo);
        n_tests++;
        if (core !== 0 || bad !== 0 || tmo || nacc !== FL || err_sop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fresh_frame: got core %0d bad=%0d beats=%0d err_sop=%b expected core 0 clean", core, bad, nacc, err_sop);
        end
    endtask

    task automatic test_back_to_back();
        int core, bad, nacc, exp_core;
        bit eop, tmo;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            if (m_cur < 0) pulse_done(int'($urandom_range(0, N - 1)));
            exp_core = m_cur;
            send_frame(FL, 1'b1, -1, -1, 1'b1, '0, core, bad, nacc, eop, tmo);
            n_tests++;
            if (core !== exp_core || bad !== 0 || tmo || nacc !== FL || !eop) begin
                n_fail++;
                $display("FAIL b2b_frame %0d: got core %0d bad=%0d tmo=%0b beats=%0d expected core %0d clean", f, core, bad, tmo, nacc, exp_core);
            end
        end
        repeat (2) tick();
        @(negedge clk);
        n_tests++;
        if (dec_busy_out !== m_busy() || {err_len, err_sop, err_credit} !== '0) begin
            n_fail++;
            $display("FAIL b2b_final: got busy=%b errs=%b%b%b expected busy=%b errs 0", dec_busy_out, err_len, err_sop, err_credit, m_busy());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        st_data_in = '0;
        st_valid_in = 1'b0;
        st_sop_in = 1'b0;
        st_eop_in = 1'b0;
        dec_ready_in = '1;
        dec_done_in = '0;
        m_reset();
        test_reset();
        test_round_robin();
        test_done_regrant();
        test_len_err();
        test_sop_err();
        test_credit_err();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
